// File: rtl/cdb_arbiter.sv
// ---------------------------------------------------------------------------
// cdb_arbiter
//
// Common Data Bus transmitter for the Tomasulo core. Each result source owns
// one holding register. Pending results are granted round-robin and driven
// onto the single CDB broadcast seen by the register status table and the
// reservation stations.
//
// Optional feature macro: CDB_BACK_TO_BACK_EN
//   undefined (default): a grant is only issued while the bus is idle, so the
//                        broadcast strobe always has a low cycle between two
//                        broadcasts (edge-capturing consumers).
//   defined            : a grant is also issued while broadcasting, so the
//                        strobe may stay high for consecutive results
//                        (level-sampling consumers only).
//
// Ports
//   clk                in   clock, all state changes on posedge
//   rst                in   synchronous, active-high reset
//   in_fu_valid        in   [N_FU]    source i offers a result
//   out_fu_ready       out  [N_FU]    source i result accepted at this edge
//   in_fu_tag          in   [5*N_FU]  tag of source i at [5i+4:5i]
//   in_fu_val          in   [32*N_FU] value of source i at [32i+31:32i]
//   out_CDB_broadcast  out  1         high one cycle per broadcast
//   out_CDB_tag        out  5         broadcast tag (holds last value)
//   out_CDB_val        out  32        broadcast value (holds last value)
//   out_drop           out  1         pulse: an INVALID_TAG result was discarded
//   out_dbg_state      out  1         FSM state (0 = IDLE, 1 = SEND)
//
// Handshake: a source transfers a result at a rising edge where both
// in_fu_valid[i] and out_fu_ready[i] are high. out_fu_ready[i] is high when
// the holding register is empty or is being granted this cycle (drain and
// refill in the same edge); it is held low while rst is high.
// ---------------------------------------------------------------------------
module cdb_arbiter #(
    parameter int         N_FU        = 4,
    parameter logic [4:0] INVALID_TAG = 5'b11111
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_FU-1:0]      in_fu_valid,
    output logic [N_FU-1:0]      out_fu_ready,
    input  logic [5*N_FU-1:0]    in_fu_tag,
    input  logic [32*N_FU-1:0]   in_fu_val,
    output logic                 out_CDB_broadcast,
    output logic [4:0]           out_CDB_tag,
    output logic [31:0]          out_CDB_val,
    output logic                 out_drop,
    output logic                 out_dbg_state
);

    localparam int             PW     = $clog2(N_FU);
    localparam logic [PW:0]    N_FU_W = (PW+1)'(N_FU);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    state_t            state_q, state_d;

    logic [N_FU-1:0]   hold_v_q, hold_v_d;
    logic [4:0]        hold_tag_q [N_FU];
    logic [4:0]        hold_tag_d [N_FU];
    logic [31:0]       hold_val_q [N_FU];
    logic [31:0]       hold_val_d [N_FU];

    logic [PW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [4:0]        cdb_tag_q, cdb_tag_d;
    logic [31:0]       cdb_val_q, cdb_val_d;
    logic              drop_q, drop_d;

    logic              grant_en;
    logic [N_FU-1:0]   grant;
    logic              grant_any;
    logic [PW-1:0]     grant_idx;
    logic [PW:0]       cand;
    logic [N_FU-1:0]   ready;

`ifdef CDB_BACK_TO_BACK_EN
    assign grant_en = 1'b1;
`else
    // Gap rule: no grant while the strobe is high.
    assign grant_en = (state_q == ST_IDLE);
`endif

    // Round-robin search starting at rr_ptr, wrapping modulo N_FU.
    always_comb begin
        grant     = '0;
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = 0; k < N_FU; k++) begin
            cand = {1'b0, rr_ptr_q} + (PW+1)'(k);
            if (cand >= N_FU_W) begin
                cand = cand - N_FU_W;
            end
            if (grant_en && !grant_any && hold_v_q[cand[PW-1:0]]) begin
                grant_any                = 1'b1;
                grant[cand[PW-1:0]]      = 1'b1;
                grant_idx                = cand[PW-1:0];
            end
        end
    end

    // Holding registers, acceptance and drop detection.
    always_comb begin
        hold_v_d   = hold_v_q;
        hold_tag_d = hold_tag_q;
        hold_val_d = hold_val_q;
        drop_d     = 1'b0;
        ready      = '0;
        for (int i = 0; i < N_FU; i++) begin
            ready[i] = !rst && (!hold_v_q[i] || grant[i]);
            if (grant[i]) begin
                hold_v_d[i] = 1'b0;
            end
            if (in_fu_valid[i] && ready[i]) begin
                if (in_fu_tag[5*i +: 5] == INVALID_TAG) begin
                    drop_d = 1'b1;
                end else begin
                    hold_v_d[i]   = 1'b1;
                    hold_tag_d[i] = in_fu_tag[5*i +: 5];
                    hold_val_d[i] = in_fu_val[32*i +: 32];
                end
            end
        end
    end

    // Pointer and broadcast payload registers follow the grant.
    always_comb begin
        rr_ptr_d  = rr_ptr_q;
        cdb_tag_d = cdb_tag_q;
        cdb_val_d = cdb_val_q;
        if (grant_any) begin
            rr_ptr_d  = (grant_idx == PW'(N_FU-1)) ? '0 : grant_idx + 1'b1;
            cdb_tag_d = hold_tag_q[grant_idx];
            cdb_val_d = hold_val_q[grant_idx];
        end
    end

    // FSM next state. In SEND a grant can only exist in back-to-back mode.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: state_d = grant_any ? ST_SEND : ST_IDLE;
            ST_SEND: state_d = grant_any ? ST_SEND : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM state register plus datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            hold_v_q  <= '0;
            rr_ptr_q  <= '0;
            cdb_tag_q <= INVALID_TAG;
            cdb_val_q <= '0;
            drop_q    <= 1'b0;
            for (int i = 0; i < N_FU; i++) begin
                hold_tag_q[i] <= INVALID_TAG;
                hold_val_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            hold_v_q   <= hold_v_d;
            rr_ptr_q   <= rr_ptr_d;
            cdb_tag_q  <= cdb_tag_d;
            cdb_val_q  <= cdb_val_d;
            drop_q     <= drop_d;
            hold_tag_q <= hold_tag_d;
            hold_val_q <= hold_val_d;
        end
    end

    // FSM outputs: the strobe is exactly the SEND state.
    always_comb begin
        out_CDB_broadcast = (state_q == ST_SEND);
        out_dbg_state     = state_q;
        out_CDB_tag       = cdb_tag_q;
        out_CDB_val       = cdb_val_q;
        out_drop          = drop_q;
        out_fu_ready      = ready;
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cdb_arbiter
//
// Directed and randomised stimulus for cdb_arbiter (N_FU = 4). A result-level
// model (pending flags per source, a round-robin pointer, the bus status)
// predicts every output each cycle; directed scenarios add literal
// expectations.
// ---------------------------------------------------------------------------
module tb_cdb_arbiter;

    localparam int         N   = 4;
    localparam logic [4:0] INV = 5'b11111;
`ifdef CDB_BACK_TO_BACK_EN
    localparam bit B2B = 1'b1;
`else
    localparam bit B2B = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    valid = '0;
    logic [5*N-1:0]  tag   = '0;
    logic [32*N-1:0] val   = '0;

    logic [N-1:0]    ready;
    logic            bcast;
    logic [4:0]      cdb_tag;
    logic [31:0]     cdb_val;
    logic            drop;
    logic            dbg_state;

    always #5 clk = ~clk;

    cdb_arbiter #(.N_FU(N), .INVALID_TAG(INV)) dut (
        .clk               (clk),
        .rst               (rst),
        .in_fu_valid       (valid),
        .out_fu_ready      (ready),
        .in_fu_tag         (tag),
        .in_fu_val         (val),
        .out_CDB_broadcast (bcast),
        .out_CDB_tag       (cdb_tag),
        .out_CDB_val       (cdb_val),
        .out_drop          (drop),
        .out_dbg_state     (dbg_state)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- result-level model ----------------
    bit          m_pend [N];
    logic [4:0]  m_tagh [N];
    logic [31:0] m_valh [N];
    int          m_ptr   = 0;
    logic        m_bcast = 1'b0;
    logic [4:0]  m_otag  = INV;
    logic [31:0] m_oval  = '0;
    logic        m_drop  = 1'b0;
    bit          model_live = 1'b0;

    // Oldest-in-turn pending source starting from the pointer, or -1.
    function automatic int model_winner();
        if (!B2B && m_bcast) return -1;
        for (int k = 0; k < N; k++) begin
            int j;
            j = (m_ptr + k) % N;
            if (m_pend[j]) return j;
        end
        return -1;
    endfunction

    always @(posedge clk) begin
        int w;
        model_live = 1'b1;
        if (rst) begin
            for (int i = 0; i < N; i++) m_pend[i] = 1'b0;
            m_ptr   = 0;
            m_bcast = 1'b0;
            m_otag  = INV;
            m_oval  = '0;
            m_drop  = 1'b0;
        end else begin
            w      = model_winner();
            m_drop = 1'b0;
            if (w >= 0) begin
                m_otag    = m_tagh[w];
                m_oval    = m_valh[w];
                m_ptr     = (w + 1) % N;
                m_pend[w] = 1'b0;
            end
            m_bcast = (w >= 0);
            for (int i = 0; i < N; i++) begin
                if (valid[i] && !m_pend[i]) begin
                    if (tag[5*i +: 5] == INV) begin
                        m_drop = 1'b1;
                    end else begin
                        m_pend[i] = 1'b1;
                        m_tagh[i] = tag[5*i +: 5];
                        m_valh[i] = val[32*i +: 32];
                    end
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        int w;
        logic [N-1:0] rexp;
        if (model_live) begin
            w = model_winner();
            for (int i = 0; i < N; i++) rexp[i] = !rst && (!m_pend[i] || w == i);
            check("cmp_bcast", 32'(bcast), 32'(m_bcast));
            check("cmp_tag",   32'(cdb_tag), 32'(m_otag));
            check("cmp_val",   cdb_val, m_oval);
            check("cmp_drop",  32'(drop), 32'(m_drop));
            check("cmp_ready", 32'(ready), 32'(rexp));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic set_src(input int i, input logic [4:0] t, input logic [31:0] v);
        tag[5*i +: 5]  = t;
        val[32*i +: 32] = v;
    endtask

    task automatic do_reset();
        valid = '0;
        rst   = 1'b1;
        tick();
        rst   = 1'b0;
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        rst = 1'b1;
        idle(2);
        check("rst_bcast", 32'(bcast), 32'd0);
        check("rst_tag",   32'(cdb_tag), 32'h1f);
        check("rst_val",   cdb_val, 32'd0);
        check("rst_drop",  32'(drop), 32'd0);
        check("rst_ready", 32'(ready), 32'h0);
        rst = 1'b0;
        #1;
        check("post_rst_ready", 32'(ready), 32'hf);

        // Single result from source 1.
        set_src(1, 5'd3, 32'h2A);
        valid = 4'b0010;
        tick();
        valid = '0;
        check("single_wait_bcast", 32'(bcast), 32'd0);
        check("single_ready1",     32'(ready[1]), 32'd1);
        tick();
        check("single_bcast", 32'(bcast), 32'd1);
        check("single_tag",   32'(cdb_tag), 32'd3);
        check("single_val",   cdb_val, 32'd42);
        check("single_ready", 32'(ready), 32'hf);
        tick();
        check("single_low",      32'(bcast), 32'd0);
        check("single_tag_hold", 32'(cdb_tag), 32'd3);
        idle(2);

        // Contention: sources 0,1,2 together right after reset.
        do_reset();
        set_src(0, 5'd10, 32'd100);
        set_src(1, 5'd11, 32'd101);
        set_src(2, 5'd12, 32'd102);
        valid = 4'b0111;
        tick();
        valid = '0;
        check("cont_ready2_e0", 32'(ready[2]), 32'd0);
        for (int e = 1; e <= 6; e++) begin
            tick();
            check("cont_bcast", 32'(bcast), 32'(e % 2));
            if (e % 2 == 1) check("cont_tag", 32'(cdb_tag), 32'(10 + (e - 1) / 2));
            check("cont_ready2", 32'(ready[2]), 32'(e >= 4));
        end
        idle(2);

        // Fairness: source 0 re-offers continuously, source 3 pending.
        do_reset();
        set_src(0, 5'd1, 32'h1000);
        set_src(3, 5'd4, 32'h4000);
        valid = 4'b1001;
        tick();
        for (int e = 1; e <= 8; e++) begin
            tick();
            if (e % 2 == 1) begin
                check("fair_bcast", 32'(bcast), 32'd1);
                check("fair_tag", 32'(cdb_tag), (e == 1 || e == 5) ? 32'd1 : 32'd4);
            end
        end
        valid = '0;
        idle(8);

        // Invalid tag from source 2 is discarded.
        set_src(2, INV, 32'hDEAD);
        valid = 4'b0100;
        tick();
        valid = '0;
        check("inv_drop",   32'(drop), 32'd1);
        check("inv_bcast",  32'(bcast), 32'd0);
        check("inv_ready2", 32'(ready[2]), 32'd1);
        tick();
        check("inv_drop_end", 32'(drop), 32'd0);
        check("inv_no_bcast", 32'(bcast), 32'd0);
        idle(2);

        // Reset while broadcasting with two results still held.
        do_reset();
        set_src(0, 5'd5, 32'h55);
        set_src(1, 5'd6, 32'h66);
        set_src(2, 5'd7, 32'h77);
        valid = 4'b0111;
        tick();
        valid = '0;
        tick();
        check("mid_bcast", 32'(bcast), 32'd1);
        check("mid_tag",   32'(cdb_tag), 32'd5);
        rst = 1'b1;
        tick();
        check("mid_rst_bcast", 32'(bcast), 32'd0);
        check("mid_rst_tag",   32'(cdb_tag), 32'h1f);
        check("mid_rst_val",   cdb_val, 32'd0);
        check("mid_rst_ready", 32'(ready), 32'h0);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("mid_quiet", 32'(bcast), 32'd0);
        end

`ifdef CDB_BACK_TO_BACK_EN
        // Back-to-back: four results stream on consecutive cycles.
        do_reset();
        for (int i = 0; i < N; i++) set_src(i, 5'(i), 32'(i + 32'h100));
        valid = 4'b1111;
        tick();
        valid = '0;
        for (int e = 1; e <= 4; e++) begin
            tick();
            check("b2b_bcast", 32'(bcast), 32'd1);
            check("b2b_tag",   32'(cdb_tag), 32'(e - 1));
        end
        tick();
        check("b2b_end", 32'(bcast), 32'd0);
`endif

        // Random traffic, checked by the model only.
        do_reset();
        for (int c = 0; c < 300; c++) begin
            valid = 4'($urandom_range(0, 15));
            for (int i = 0; i < N; i++) begin
                set_src(i, ($urandom_range(0, 7) == 0) ? INV : 5'($urandom_range(0, 30)),
                        $urandom);
            end
            tick();
        end
        valid = '0;
        idle(12);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
